// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, request
// packet field positions and the default access latency.
package dmem_responder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int WR_BIT          = 64;
  localparam int ADDR_HI         = 63;
  localparam int ADDR_LO         = 32;
  localparam int DATA_HI         = 31;
  localparam int DEFAULT_LATENCY = 2;
  // Wide enough for the largest legal latency (15).
  localparam int CNT_W           = 4;

endpackage

// File: rtl/dmem_responder_array.sv
// Synchronous single-port 32-bit RAM with write enable and a registered,
// read-first output. Contents are not reset.
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    rdata_q <= mem_q[addr_i];
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word request at a time, completes it
// LATENCY cycles later. Define DMEM_ALIGN_CHECK_EN to flag misaligned requests.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        stop,
  input  logic [64:0] req_packet,
  output logic [31:0] mem_out,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output state_e      dbg_state_o
);

  // Request handshake: a request is taken on an edge where state is IDLE,
  // enable=1 and stop=0; busy covers that cycle and every in-flight cycle.
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              bad_q, bad_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       mem_out_q, mem_out_d;
  logic              done_q, done_d;

  logic              accept;
  logic              complete;
  logic              req_bad;
  logic [ADDR_W-1:0] req_idx;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;

  assign req_idx = req_packet[ADDR_LO+ADDR_W+1:ADDR_LO+2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q;
  assign req_bad = (req_packet[ADDR_LO+1:ADDR_LO] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else if (accept && req_bad) begin
      mis_q <= 1'b1;
    end
  end

  assign misaligned = mis_q;
  wire unused_addr = ^req_packet[ADDR_HI:ADDR_LO+ADDR_W+2];
`else
  assign req_bad    = 1'b0;
  assign misaligned = 1'b0;
  wire unused_addr  = ^{req_packet[ADDR_HI:ADDR_LO+ADDR_W+2],
                        req_packet[ADDR_LO+1:ADDR_LO]};
`endif

  assign accept   = (state_q == ST_IDLE) && enable && !stop;
  assign complete = (state_q == ST_BUSY) && (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    bad_d     = bad_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    mem_out_d = mem_out_q;
    done_d    = complete;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          wr_d    = req_packet[WR_BIT];
          bad_d   = req_bad;
          idx_d   = req_idx;
          wdata_d = req_packet[DATA_HI:0];
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (!wr_q && !bad_q) begin
            mem_out_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      bad_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      mem_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      bad_q     <= bad_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      mem_out_q <= mem_out_d;
      done_q    <= done_d;
    end
  end

  // Address the RAM with the live request while idle so the registered read
  // data is already valid by the completion edge, even for LATENCY=1.
  assign ram_addr = (state_q == ST_IDLE) ? req_idx : idx_q;
  assign ram_we   = complete && wr_q && !bad_q;

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign mem_out     = mem_out_q;
  assign busy        = (state_q == ST_BUSY) || accept;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a transaction-level memory model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int AW    = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        stop = 1'b0;
  logic [64:0] req_packet = '0;
  logic [31:0] mem_out;
  logic        busy;
  logic        done;
  logic        misaligned;
  state_e      dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q[$];
  logic [31:0] exp_mem_out = '0;
  logic        exp_done = 1'b0;
  logic        exp_mis = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W (AW),
    .LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .stop       (stop),
    .req_packet (req_packet),
    .mem_out    (mem_out),
    .busy       (busy),
    .done       (done),
    .misaligned (misaligned),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then step past the next edge.
  task automatic cyc(input logic exp_busy);
    @(negedge clk);
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
    check("mem_out", mem_out, exp_mem_out);
    check("misaligned", 32'(misaligned), 32'(exp_mis));
    @(posedge clk);
    #1;
    exp_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      enable = 1'($urandom_range(0, 1));
      stop   = enable ? 1'b1 : 1'($urandom_range(0, 1));
      req_packet = {1'($urandom), 32'($urandom), 32'($urandom)};
      cyc(1'b0);
    end
    enable = 1'b0;
    stop   = 1'b0;
  endtask

  // Present one request (held off by stop for stop_cycles), scramble the
  // inputs while it is in flight, and update the model at completion.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input int stop_cycles);
    bit bad;
    int idx;
    bad = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    bad = (addr[1:0] != 2'b00);
`endif
    idx = int'(addr[AW+1:2]);
    if (!wr && !bad) exp_q.push_back(model_mem[idx]);
    enable = 1'b1;
    req_packet = {wr, addr, data};
    stop = (stop_cycles > 0);
    for (int k = 0; k < stop_cycles; k++) cyc(1'b0);
    stop = 1'b0;
    cyc(1'b1);
    if (bad) exp_mis = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      req_packet = {1'($urandom), 32'($urandom), 32'($urandom)};
      enable = 1'($urandom_range(0, 1));
      stop   = 1'($urandom_range(0, 1));
      if (i == LAT - 1) begin
        enable = 1'b0;
        stop   = 1'b0;
      end
      cyc(1'b1);
    end
    if (wr && !bad) model_mem[idx] = data;
    if (!wr && !bad) exp_mem_out = exp_q.pop_front();
    exp_done = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_out", mem_out, 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int w = 0; w < DEPTH; w++) issue(1'b1, 32'(w * 4), 32'd0, 0);

    // Reset in the middle of a store aborts it.
    enable = 1'b1;
    req_packet = {1'b1, 32'h40, 32'hDEADBEEF};
    cyc(1'b1);
    enable = 1'b0;
    cyc(1'b1);
    reset = 1'b1;
    #2;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_mem_out", mem_out, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_done = 1'b0;
    exp_mem_out = '0;
    exp_mis = 1'b0;
    cyc(1'b0);

    issue(1'b1, 32'h10, 32'h12345678, 0);
    issue(1'b0, 32'h10, 32'h0, 0);
    issue(1'b0, 32'h40, 32'h0, 1);

    issue(1'b1, 32'h50, 32'hCAFEF00D, 3);
    issue(1'b0, 32'h50, 32'h0, 0);

    issue(1'b1, 32'h20, 32'hA5A5A5A5, 0);
    issue(1'b1, 32'h24, 32'h5A5A5A5A, 0);
    issue(1'b0, 32'h20, 32'h0, 0);

    issue(1'b1, 32'h0000_0000, 32'h1, 0);
    issue(1'b1, 32'h0000_1000, 32'h2, 0);
    issue(1'b0, 32'h0000_0000, 32'h0, 0);

`ifdef DMEM_ALIGN_CHECK_EN
    issue(1'b1, 32'h13, 32'hFFFFFFFF, 0);
    idle(2);
    issue(1'b0, 32'h10, 32'h0, 0);
`endif

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 7)) << 2;
      else a = $urandom;
`ifdef DMEM_ALIGN_CHECK_EN
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
`endif
      issue(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    cyc(1'b0);
    cyc(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
